// File: rtl/recovery_rf_restore_pkg.sv
// Shared definitions for the HMR register-file restore sequencer.
package recovery_rf_restore_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } restore_state_e;

endpackage

// File: rtl/recovery_rf_restore_pipe.sv
// Stall-holding register for one read pair on its way to the core RF write ports.
module recovery_rf_restore_pipe #(
  parameter type pair_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  stall_i,
  input  logic  load_i,
  input  pair_t pair_i,
  output logic  valid_o,
  output pair_t pair_o
);

  logic  valid_q, valid_d;
  pair_t pair_q, pair_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    pair_d  = pair_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      // The held pair is consumed this cycle; replace it or go empty.
      valid_d = load_i;
      if (load_i) begin
        pair_d = pair_i;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pair_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pair_q  <= pair_d;
    end
  end

  assign valid_o = valid_q;
  assign pair_o  = pair_q;

endmodule

// File: rtl/recovery_rf_restore.sv
// Restore sequencer: walks the recovery RF two words per cycle, replays each pair
// into the core RF through its two write ports, then pulses done to the controller.
module recovery_rf_restore
  import recovery_rf_restore_pkg::*;
#(
  parameter  int unsigned DataWidth = 32,
  parameter  int unsigned NumWords  = 32,
  localparam int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 stall_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AddrWidth-1:0] raddr_a_o,
  output logic [AddrWidth-1:0] raddr_b_o,
  input  logic [DataWidth-1:0] rdata_a_i,
  input  logic [DataWidth-1:0] rdata_b_i,
  output logic [AddrWidth-1:0] waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic [AddrWidth-1:0] waddr_b_o,
  output logic [DataWidth-1:0] wdata_b_o,
  output logic                 we_b_o
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr_a;
    logic [DataWidth-1:0] data_a;
    logic [AddrWidth-1:0] addr_b;
    logic [DataWidth-1:0] data_b;
  } restore_pair_t;

  localparam logic [AddrWidth-1:0] LastCnt = AddrWidth'(NumWords - 2);

  restore_state_e       state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [AddrWidth-1:0] raddr_a, raddr_b;
  logic                 load;
  logic                 pipe_valid;
  restore_pair_t        load_pair;
  restore_pair_t        pipe_pair;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (!stall_i) begin
          load = 1'b1;
          // Leave before the final increment so the counter never wraps.
          if (cnt_q == LastCnt) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + AddrWidth'(2);
          end
        end
      end
      DRAIN: begin
        if (pipe_valid && !stall_i) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      load    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt is always even, so OR-ing in the busy bit gives cnt+1 while restoring
  // and keeps port B at zero out of reset.
  assign raddr_a = cnt_q;
  assign raddr_b = cnt_q | AddrWidth'(state_q != IDLE);

  always_comb begin
    load_pair = '{addr_a: raddr_a, data_a: rdata_a_i,
                  addr_b: raddr_b, data_b: rdata_b_i};
  end

  recovery_rf_restore_pipe #(
    .pair_t (restore_pair_t)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (abort_i),
    .stall_i (stall_i),
    .load_i  (load),
    .pair_i  (load_pair),
    .valid_o (pipe_valid),
    .pair_o  (pipe_pair)
  );

  assign raddr_a_o = raddr_a;
  assign raddr_b_o = raddr_b;
  assign waddr_a_o = pipe_pair.addr_a;
  assign wdata_a_o = pipe_pair.data_a;
  assign waddr_b_o = pipe_pair.addr_b;
  assign wdata_b_o = pipe_pair.data_b;

  // x0 is hard-wired zero in the core, so its write is dropped.
  assign we_b_o = pipe_valid & ~stall_i & ~abort_i;
  assign we_a_o = we_b_o & (pipe_pair.addr_a != '0);

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE) & ~abort_i;

endmodule

// File: tb/tb_recovery_rf_restore.sv
// Bench for recovery_rf_restore: directed and randomized restores on a 32-word
// and a 64-word instance, checked against a productive-cycle count model.
module tb_recovery_rf_restore;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, stall, sel;

  logic start32, abort32, stall32, start64, abort64, stall64;
  assign start32 = sel ? 1'b0 : start;
  assign abort32 = sel ? 1'b0 : abort;
  assign stall32 = sel ? 1'b0 : stall;
  assign start64 = sel ? start : 1'b0;
  assign abort64 = sel ? abort : 1'b0;
  assign stall64 = sel ? stall : 1'b0;

  logic [31:0] rf [64];

  logic        busy32, done32, we_a32, we_b32;
  logic [4:0]  raddr_a32, raddr_b32, waddr_a32, waddr_b32;
  logic [31:0] wdata_a32, wdata_b32, rdata_a32, rdata_b32;
  logic        busy64, done64, we_a64, we_b64;
  logic [5:0]  raddr_a64, raddr_b64, waddr_a64, waddr_b64;
  logic [31:0] wdata_a64, wdata_b64, rdata_a64, rdata_b64;

  assign rdata_a32 = rf[{1'b0, raddr_a32}];
  assign rdata_b32 = rf[{1'b0, raddr_b32}];
  assign rdata_a64 = rf[raddr_a64];
  assign rdata_b64 = rf[raddr_b64];

  recovery_rf_restore #(.DataWidth(32), .NumWords(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .abort_i(abort32), .stall_i(stall32),
    .busy_o(busy32), .done_o(done32), .raddr_a_o(raddr_a32), .raddr_b_o(raddr_b32),
    .rdata_a_i(rdata_a32), .rdata_b_i(rdata_b32),
    .waddr_a_o(waddr_a32), .wdata_a_o(wdata_a32), .we_a_o(we_a32),
    .waddr_b_o(waddr_b32), .wdata_b_o(wdata_b32), .we_b_o(we_b32)
  );

  recovery_rf_restore #(.DataWidth(32), .NumWords(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .start_i(start64), .abort_i(abort64), .stall_i(stall64),
    .busy_o(busy64), .done_o(done64), .raddr_a_o(raddr_a64), .raddr_b_o(raddr_b64),
    .rdata_a_i(rdata_a64), .rdata_b_i(rdata_b64),
    .waddr_a_o(waddr_a64), .wdata_a_o(wdata_a64), .we_a_o(we_a64),
    .waddr_b_o(waddr_b64), .wdata_b_o(wdata_b64), .we_b_o(we_b64)
  );

  logic        o_busy, o_done, o_we_a, o_we_b;
  logic [5:0]  o_raddr_a, o_raddr_b, o_waddr_a, o_waddr_b;
  logic [31:0] o_wdata_a, o_wdata_b;

  always_comb begin
    if (sel) begin
      o_busy = busy64; o_done = done64; o_we_a = we_a64; o_we_b = we_b64;
      o_raddr_a = raddr_a64; o_raddr_b = raddr_b64;
      o_waddr_a = waddr_a64; o_waddr_b = waddr_b64;
      o_wdata_a = wdata_a64; o_wdata_b = wdata_b64;
    end else begin
      o_busy = busy32; o_done = done32; o_we_a = we_a32; o_we_b = we_b32;
      o_raddr_a = {1'b0, raddr_a32}; o_raddr_b = {1'b0, raddr_b32};
      o_waddr_a = {1'b0, waddr_a32}; o_waddr_b = {1'b0, waddr_b32};
      o_wdata_a = wdata_a32; o_wdata_b = wdata_b32;
    end
  end

  // Reference model: a restore is a count p of non-stalled cycles since start.
  // Cycles with p in 1..N/2 write pair p-1; p == N/2+1 is the done cycle.
  int n_words;
  bit m_busy, m_zero, aborted;
  int p, cyc, done_cyc, done_cnt;
  int wcount [64];
  int checks, failures;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit a, input bit st);
    int  half, pa;
    bit  exp_we_a, exp_we_b;
    rst = r; start = s; abort = a; stall = st;
    @(negedge clk);
    half = n_words / 2;
    if (m_zero) begin
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_we_a", o_we_a, 0);
      check("rst_we_b", o_we_b, 0);
      check("rst_raddr_a", o_raddr_a, 0);
      check("rst_raddr_b", o_raddr_b, 0);
      check("rst_waddr_a", o_waddr_a, 0);
      check("rst_waddr_b", o_waddr_b, 0);
      check("rst_wdata_a", o_wdata_a, 0);
      check("rst_wdata_b", o_wdata_b, 0);
    end else begin
      pa       = 2 * (p - 1);
      exp_we_b = m_busy && !a && !st && p >= 1 && p <= half;
      exp_we_a = exp_we_b && pa != 0;
      check("busy", o_busy, m_busy);
      check("done", o_done, m_busy && p == half + 1 && !a);
      check("we_b", o_we_b, exp_we_b);
      check("we_a", o_we_a, exp_we_a);
      if (exp_we_b) begin
        check("waddr_b", o_waddr_b, pa + 1);
        check("wdata_b", o_wdata_b, rf[pa + 1]);
      end
      if (exp_we_a) begin
        check("waddr_a", o_waddr_a, pa);
        check("wdata_a", o_wdata_a, rf[pa]);
      end
      if (m_busy && p < half) begin
        check("raddr_a", o_raddr_a, 2 * p);
        check("raddr_b", o_raddr_b, 2 * p + 1);
      end
    end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_we_a) wcount[o_waddr_a]++;
    if (o_we_b) wcount[o_waddr_b]++;
    m_zero = r;
    if (r) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (a) aborted = 1'b1;
      if (a || p == half + 1) m_busy = 1'b0;
      else if (!st) p++;
    end else if (s && !a) begin
      m_busy = 1'b1;
      p      = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 64; i++) wcount[i] = 0;
    done_cnt = 0;
    done_cyc = -1;
    aborted  = 1'b0;
  endtask

  task automatic preload(input bit pattern);
    for (int i = 0; i < 64; i++) rf[i] = pattern ? 32'hA500_0000 + 32'(i) : $urandom;
  endtask

  task automatic run_to_idle(input int stall_pct, input int abort_per_mille);
    int guard;
    guard = 0;
    while (m_busy && guard < 1000) begin
      step(1'b0, 1'b0, $urandom_range(999) < abort_per_mille, $urandom_range(99) < stall_pct);
      guard++;
    end
    check("run_timeout", m_busy, 0);
  endtask

  task automatic check_writes();
    for (int i = 0; i < n_words; i++) check("write_count", wcount[i], (i == 0) ? 0 : 1);
  endtask

  int c0;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    sel = 1'b0; n_words = 32;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    m_busy = 1'b0; p = 0;
    preload(1'b1);
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    m_zero = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Plain restore, 32 words.
    clear_counts();
    c0 = cyc;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle(0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_done_cycle", done_cyc - c0, 18);
    check("t1_done_count", done_cnt, 1);
    check_writes();

    // Stall during cycles 3..6.
    clear_counts();
    c0 = cyc;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    while (m_busy && cyc - c0 < 100) step(1'b0, 1'b0, 1'b0, (cyc - c0 >= 3) && (cyc - c0 <= 6));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_done_cycle", done_cyc - c0, 22);
    check_writes();

    // Abort at cycle 5, restart at cycle 8.
    clear_counts();
    c0 = cyc;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    while (cyc - c0 < 8) step(1'b0, 1'b0, cyc - c0 == 5, 1'b0);
    check("t3_no_done", done_cnt, 0);
    clear_counts();
    c0 = cyc;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle(0, 0);
    check("t3_restart_done_cycle", done_cyc - c0, 18);
    check_writes();

    // Reset mid-READ, then start again in the cycle right after.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    clear_counts();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle(0, 0);
    check_writes();

    // 64-word instance: f0 at address 32 is restored.
    sel = 1'b1; n_words = 64;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    clear_counts();
    c0 = cyc;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle(0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_done_cycle", done_cyc - c0, 34);
    check("t5_f0_written", wcount[32], 1);
    check_writes();

    // start_i held high: one sequence, re-accepted only once back in IDLE.
    sel = 1'b0; n_words = 32;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    clear_counts();
    c0 = cyc;
    repeat (19) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_single_done", done_cnt, 1);
    check("t6_done_cycle", done_cyc - c0, 18);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized data, stalls and rare aborts on both sizes.
    for (int run = 0; run < 8; run++) begin
      sel = run[0];
      n_words = sel ? 64 : 32;
      preload(1'b0);
      step(1'b0, 1'b0, 1'b0, $urandom_range(1));
      clear_counts();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      run_to_idle(30, (run > 5) ? 20 : 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (!aborted) begin
        check("rand_done_count", done_cnt, 1);
        check_writes();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recovery_rf_restore.md
Name: recovery_rf_restore

Overview:
- Restore sequencer that sits directly downstream of the HMR recovery register file.
- After a fault is detected and the cores are reset, it walks every word of the recovery register file using two read ports per cycle.
- It replays each word into the core register file through the core's two write ports.
- It signals completion to the HMR recovery controller, which then releases the cores.

Parameters:
- DataWidth, 32, width of one register word as seen on the recovery RF read ports (already ECC-decoded).
- NumWords, 32, words to restore: 32 for integer only, 64 when a separate FP register file exists. Must be even and a power of two.
- AddrWidth, $clog2(NumWords), localparam for the read/write address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  single-cycle request to begin restore.
- abort_i  in  1  abandon restore immediately.
- stall_i  in  1  core write ports unavailable this cycle.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  single-cycle pulse when the last write has been issued.
- raddr_a_o  out  AddrWidth  recovery RF read address, port A.
- raddr_b_o  out  AddrWidth  recovery RF read address, port B.
- rdata_a_i  in  DataWidth  recovery RF read data, port A (combinational, same cycle).
- rdata_b_i  in  DataWidth  recovery RF read data, port B (combinational, same cycle).
- waddr_a_o  out  AddrWidth  core RF write address, port A.
- wdata_a_o  out  DataWidth  core RF write data, port A.
- we_a_o  out  1  core RF write enable, port A.
- waddr_b_o  out  AddrWidth  core RF write address, port B.
- wdata_b_o  out  DataWidth  core RF write data, port B.
- we_b_o  out  1  core RF write enable, port B.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE, counter 0, pipeline valid 0. busy_o, done_o, we_a_o and we_b_o are 0. All address and data outputs are 0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start_i=1 -> READ, with counter cnt=0 and busy_o=1 from the next cycle.
  - start_i while not IDLE is ignored.
- READ:
  - raddr_a_o=cnt, raddr_b_o=cnt+1.
  - When stall_i=0:
    - Capture rdata_a_i/rdata_b_i and the addresses into the pipeline register.
    - Set valid_q=1 and cnt+=2.
    - When cnt==NumWords-2 -> DRAIN.
  - When stall_i=1: cnt and the pipeline register hold.
- Write stage:
  - Outputs are driven from the pipeline register.
  - we_a_o = valid_q & ~stall_i & (waddr_a_o!=0); word 0 (x0) is never written.
  - we_b_o = valid_q & ~stall_i.
  - The pipeline register only advances when stall_i=0, so no word is lost or duplicated.
- DRAIN:
  - Waits until the final pair is written (valid_q & ~stall_i), then -> DONE.
  - No reads are issued; raddr outputs hold their last value.
- DONE: done_o=1 and busy_o=1 for exactly one cycle -> IDLE, busy_o=0 next cycle.
- Latency: with no stalls, first write appears 1 cycle after entering READ. done_o asserts NumWords/2+2 cycles after start_i (18 for NumWords=32).
- Counter and addresses: cnt is AddrWidth bits wide. The last pair is NumWords-2/NumWords-1. No wrap-around occurs because the transition to DRAIN happens before the increment overflows.
- Abort:
  - abort_i=1 in any state -> IDLE next cycle; valid_q cleared, busy_o=0, done_o not pulsed.
  - Write enables are forced 0 in the abort cycle.
  - abort_i has priority over start_i.
- Reset mid-operation is identical to abort, and additionally zeroes all registers.
- stall_i in IDLE or DONE has no effect.

Decomposition:
- Shared HMR package:
  - restore_state_e enum (IDLE, READ, DRAIN, DONE).
  - A restore_pair_t struct {addr_a, data_a, addr_b, data_b} parameterised by width, used for the pipeline register.
- One natural sub-module, recovery_rf_restore_pipe: the stall-holding pair register with its valid bit.
- The FSM and counter stay in the top module.

Test Plan:
- NumWords=32; recovery RF word i preloaded with 0xA5000000+i; pulse start_i; no stalls -> write 0 suppressed; writes at waddr 1..31 carry 0xA5000001..0xA500001F; done_o at cycle 18; busy_o low at cycle 19.
- Same preload; stall_i high for cycles 3-6 -> write sequence identical and each address written exactly once; done_o delayed by 4 cycles to cycle 22.
- abort_i pulsed at cycle 5 -> no we_* in cycle 5 or later, no done_o, busy_o=0 at cycle 6; a new start_i at cycle 8 restarts from cnt=0.
- rst_i asserted mid-READ for 1 cycle -> next cycle all outputs 0 and state IDLE; start_i re-accepted afterwards.
- NumWords=64 (FP present) -> 32 read cycles; word 32 (f0) is written (we_b_o or we_a_o as applicable) while only address 0 is suppressed; done_o at cycle 34.
- start_i held high for the whole run -> only one restore sequence occurs; a second start_i is accepted only once IDLE is reached again after DONE.
